dm_dump_uart: RTL and testbench

DM_DUMP_UART -- requirements
Module: dm_dump_uart

---
 rtl/dm_dump_uart.sv | 145 ++++++++++++++
 tb/tb_dm_dump_uart.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_dump_uart.sv
// Streams DEPTH 32-bit data-memory words out of an 8N1 UART, least significant byte first.
// Exposes the FSM state on state_dbg so external checkers can follow the dump.
module dm_dump_uart #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [4:0]  mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic [2:0]  state_dbg
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [4:0] ADDR_LAST = 5'(DEPTH - 1);

  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP, DONE} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_n;
  logic [1:0]       byte_idx, byte_n;
  logic [31:0]      word, word_n;
  logic [4:0]       addr_n;
  logic             armed;
  logic             bit_end;
  logic             tx_n, busy_n, done_n;

  // Handshake: start is a single-cycle request with no ready; it is honoured
  // only in IDLE and only once the first clock after reset release has passed.
  assign bit_end   = (cnt == CNT_LAST);
  assign state_dbg = state;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    byte_n  = byte_idx;
    word_n  = word;
    addr_n  = mem_addr;
    case (state)
      IDLE: begin
        addr_n = '0;
        if (start && armed) state_n = FETCH;
      end
      FETCH: begin
        word_n  = mem_rdata;
        byte_n  = '0;
        bit_n   = '0;
        cnt_n   = '0;
        state_n = START;
      end
      START: begin
        if (bit_end) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n = '0;
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_n   = bit_idx + 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_n = '0;
          if (byte_idx != 2'd3) begin
            byte_n  = byte_idx + 1'b1;
            state_n = START;
          end else if (mem_addr < ADDR_LAST) begin
            addr_n  = mem_addr + 1'b1;
            state_n = FETCH;
          end else begin
            addr_n  = '0;
            state_n = DONE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are computed from the next state so the registered values line up with the state.
  always_comb begin
    tx_n   = 1'b1;
    busy_n = 1'b0;
    done_n = 1'b0;
    case (state_n)
      FETCH:   busy_n = 1'b1;
      START: begin
        busy_n = 1'b1;
        tx_n   = 1'b0;
      end
      DATA: begin
        busy_n = 1'b1;
        tx_n   = word_n[{byte_n, bit_n}];
      end
      STOP:    busy_n = 1'b1;
      DONE:    done_n = 1'b1;
      default: tx_n   = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      word     <= '0;
      mem_addr <= '0;
      armed    <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_n;
      byte_idx <= byte_n;
      word     <= word_n;
      mem_addr <= addr_n;
      armed    <= 1'b1;
      tx       <= tx_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

endmodule

// File: tb/tb_dm_dump_uart.sv
// Directed bench for dm_dump_uart: a serial decoder pops expected bytes from a scoreboard queue.
// Instance a is CLKS_PER_BIT=4/DEPTH=2, instance b is CLKS_PER_BIT=4 with the default depth.
module tb_dm_dump_uart;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_a, start_b;
  logic [4:0]  addr_a, addr_b;
  logic [31:0] rdata_a, rdata_b;
  logic        tx_a, tx_b, busy_a, busy_b, done_a, done_b;
  logic [2:0]  st_a, st_b;

  logic [31:0] mem_a [0:1];
  logic [31:0] mem_b [0:31];

  assign rdata_a = mem_a[addr_a[0]];
  assign rdata_b = mem_b[addr_b];

  dm_dump_uart #(.CLKS_PER_BIT(CPB), .DEPTH(2)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .mem_addr(addr_a), .mem_rdata(rdata_a),
    .tx(tx_a), .busy(busy_a), .done(done_a), .state_dbg(st_a)
  );

  dm_dump_uart #(.CLKS_PER_BIT(CPB)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .mem_addr(addr_b), .mem_rdata(rdata_b),
    .tx(tx_b), .busy(busy_b), .done(done_b), .state_dbg(st_b)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // scoreboard state
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];
  logic [4:0] addr_log[$];

  logic       sel_b = 1'b0;
  logic       tx_mon, busy_mon, done_mon;
  logic [4:0] addr_mon;
  assign tx_mon   = sel_b ? tx_b   : tx_a;
  assign busy_mon = sel_b ? busy_b : busy_a;
  assign done_mon = sel_b ? done_b : done_a;
  assign addr_mon = sel_b ? addr_b : addr_a;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // monitor + serial decoder, sampled on the falling edge
  int         cyc = 0;
  int         busy_rise = 0, done_cyc = 0, done_cnt = 0, first_low = 0;
  int         bytes_rx = 0, rx_t = 0;
  logic       busy_prev = 1'b0, first_pending = 1'b0, rx_active = 1'b0;
  logic       frame_ok = 1'b1, cur_bit = 1'b0;
  logic [7:0] rx_byte = '0;
  logic [4:0] addr_prev = '0, addr_peak = '0;
  logic [8:0] exp_b;

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      rx_active = 1'b0;
      busy_prev = 1'b0;
    end else begin
      if (busy_mon && !busy_prev) begin
        busy_rise     = cyc;
        first_pending = 1'b1;
      end
      busy_prev = busy_mon;
      if (done_mon) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (addr_mon != addr_prev) addr_log.push_back(addr_mon);
      if (addr_mon > addr_peak) addr_peak = addr_mon;
      if (!rx_active && tx_mon === 1'b0) begin
        rx_active = 1'b1;
        rx_t      = 0;
        frame_ok  = 1'b1;
        rx_byte   = '0;
        if (first_pending) begin
          first_low     = cyc;
          first_pending = 1'b0;
        end
      end
      if (rx_active) begin
        if (rx_t < CPB) begin
          frame_ok &= (tx_mon === 1'b0);
        end else if (rx_t < 9 * CPB) begin
          if ((rx_t - CPB) % CPB == 0) begin
            cur_bit = tx_mon;
            rx_byte[(rx_t - CPB) / CPB] = tx_mon;
          end else begin
            frame_ok &= (tx_mon === cur_bit);
          end
        end else begin
          frame_ok &= (tx_mon === 1'b1);
        end
        if (rx_t == 10 * CPB - 1) begin
          rx_active = 1'b0;
          bytes_rx++;
          check("frame_timing", {31'd0, frame_ok}, 32'd1);
          exp_b = (exp_q.size() != 0) ? {1'b0, exp_q.pop_front()} : 9'h100;
          check("rx_byte", {24'd0, rx_byte}, {23'd0, exp_b});
        end
        rx_t++;
      end
    end
    addr_prev = addr_mon;
  end

  // driver tasks
  task automatic pulse_start(input logic b);
    @(negedge clk);
    if (b) start_b = 1'b1;
    else   start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
  endtask

  task automatic wait_done(input int budget);
    int n;
    int d0;
    n  = 0;
    d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("done_within_budget", {31'd0, done_cnt != d0}, 32'd1);
  endtask

  int base, d0, n;

  initial begin
    reset   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    mem_a[0] = 32'h1234_5678;
    mem_a[1] = 32'hA5A5_A5A5;
    for (int i = 0; i < 32; i++) mem_b[i] = i;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", {31'd0, tx_a}, 32'd1);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_done", {31'd0, done_a}, 32'd0);
    check("rst_addr", {27'd0, addr_a}, 32'd0);
    check("rst_state", {29'd0, st_a}, 32'd0);

    // start held across the release edge must be ignored
    @(negedge clk);
    reset   = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("start_at_release_busy", {31'd0, busy_a}, 32'd0);
    check("start_at_release_state", {29'd0, st_a}, 32'd0);

    // two-word dump, repeated starts while busy, memory overwritten mid-word
    push_word(32'h1234_5678);
    push_word(32'hA5A5_A5A5);
    addr_log.delete();
    addr_peak = '0;
    done_cnt  = 0;
    base      = bytes_rx;
    pulse_start(1'b0);
    repeat (3) @(negedge clk);
    mem_a[0] = 32'hFFFF_FFFF;
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(10, 35)) @(negedge clk);
      pulse_start(1'b0);
    end
    wait_done(800);
    check("dump_latency", done_cyc - busy_rise, 32'd322);
    check("first_start_bit", first_low - busy_rise, 32'd1);
    check("dump_bytes", bytes_rx - base, 32'd8);
    check("dump_queue_left", exp_q.size(), 32'd0);
    check("addr_log_len", addr_log.size(), 32'd2);
    check("addr_log_0", {27'd0, addr_log[0]}, 32'd1);
    check("addr_log_1", {27'd0, addr_log[1]}, 32'd0);
    check("addr_peak_a", {27'd0, addr_peak}, 32'd1);
    #1;
    check("done_single_cycle", {31'd0, done_a}, 32'd0);
    repeat (200) @(posedge clk);
    #1;
    check("no_queued_dump_done", done_cnt, 32'd1);
    check("no_queued_dump_busy", {31'd0, busy_a}, 32'd0);
    mem_a[0] = 32'h1234_5678;

    // asynchronous reset during word 1 byte 2 data bits
    push_word(32'h1234_5678);
    push_word(32'hA5A5_A5A5);
    base = bytes_rx;
    d0   = done_cnt;
    pulse_start(1'b0);
    n = 0;
    while (bytes_rx < base + 6 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    check("reach_word1_byte2", bytes_rx - base, 32'd6);
    n = 0;
    while (!(st_a == 3'd3 && tx_a == 1'b0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_rst_tx", {31'd0, tx_a}, 32'd1);
    check("async_rst_busy", {31'd0, busy_a}, 32'd0);
    check("async_rst_state", {29'd0, st_a}, 32'd0);
    check("async_rst_addr", {27'd0, addr_a}, 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt, d0);
    check("abort_idle_busy", {31'd0, busy_a}, 32'd0);

    push_word(32'h1234_5678);
    push_word(32'hA5A5_A5A5);
    addr_log.delete();
    base = bytes_rx;
    pulse_start(1'b0);
    wait_done(800);
    check("redump_latency", done_cyc - busy_rise, 32'd322);
    check("redump_bytes", bytes_rx - base, 32'd8);
    check("redump_queue_left", exp_q.size(), 32'd0);
    check("redump_addr_first", {27'd0, addr_log[0]}, 32'd1);

    // full default-depth dump, MEM[i]=i
    repeat (5) @(posedge clk);
    sel_b = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 32; i++) push_word(i);
    addr_peak = '0;
    base      = bytes_rx;
    pulse_start(1'b1);
    wait_done(6000);
    check("deep_latency", done_cyc - busy_rise, 32'd5152);
    check("deep_bytes", bytes_rx - base, 32'd128);
    check("deep_queue_left", exp_q.size(), 32'd0);
    check("deep_addr_peak", {27'd0, addr_peak}, 32'd31);
    @(posedge clk);
    #1;
    check("deep_addr_return", {27'd0, addr_b}, 32'd0);
    check("deep_busy_end", {31'd0, busy_b}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
